alu_issue: RTL

- Operand-fetch/issue stage directly upstream of the ALU.
- Accepts a 32-bit instruction word, decodes it, reads two sources from a 32x64 register file, and holds the registered operand1/operand2/op bundle for the ALU under a valid/ready handshake.
- Owns the writeback port that commits ALU results into the register file.
- Keeps a per-register pending scoreboard so no instruction issues on a stale source.

---
 rtl/alu_issue_pkg.sv | 46 ++++
 rtl/alu_issue_if.sv | 23 ++
 rtl/alu_issue_regfile.sv | 46 ++++
 rtl/alu_issue.sv | 112 +++++++++++
 4 files changed

// File: rtl/alu_issue_pkg.sv
// Shared CPU package: widths, instruction layout and ALU opcode set.
// Imported as cpu_pkg by the issue stage, its regfile and the ALU.
package cpu_pkg;

    localparam int XLEN   = 64;
    localparam int OPW    = 5;
    localparam int NREGS  = 32;
    localparam int REG_AW = $clog2(NREGS);

    typedef enum logic [OPW-1:0] {
        ALU_ADD  = 5'd0,
        ALU_SUB  = 5'd1,
        ALU_AND  = 5'd2,
        ALU_OR   = 5'd3,
        ALU_XOR  = 5'd4,
        ALU_SLL  = 5'd5,
        ALU_SRL  = 5'd6,
        ALU_SRA  = 5'd7,
        ALU_SLT  = 5'd8,
        ALU_SLTU = 5'd9
    } alu_op_e;

    typedef struct packed {
        logic [REG_AW-1:0] rs2;
        logic [10:0]       rsvd;
    } lo_reg_t;

    // rs2 and imm16 share the low half of the word
    typedef union packed {
        lo_reg_t     r;
        logic [15:0] imm16;
    } lo_t;

    typedef struct packed {
        logic              imm_sel;
        logic [OPW-1:0]    op;
        logic [REG_AW-1:0] rd;
        logic [REG_AW-1:0] rs1;
        lo_t               lo;
    } instr_t;

    function automatic logic [XLEN-1:0] sext16(input logic [15:0] v);
        return {{(XLEN-16){v[15]}}, v};
    endfunction

endpackage

// File: rtl/alu_issue_if.sv
// Issue-to-ALU bundle: registered operands, opcode and destination tag.
// master = issue stage, slave = ALU.
interface alu_issue_if;
    import cpu_pkg::*;

    logic              issue_valid;
    logic              issue_ready;
    logic [XLEN-1:0]   operand1;
    logic [XLEN-1:0]   operand2;
    logic [OPW-1:0]    op;
    logic [REG_AW-1:0] rd_out;

    modport master (
        output issue_valid, operand1, operand2, op, rd_out,
        input  issue_ready
    );

    modport slave (
        input  issue_valid, operand1, operand2, op, rd_out,
        output issue_ready
    );

endinterface

// File: rtl/alu_issue_regfile.sv
// NREGS x XLEN register file, 2 async reads, 1 sync write, r0 = 0.
// ALU_ISSUE_BYPASS_EN adds write-through forwarding on both read ports.
module regfile
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [XLEN-1:0]   wdata,
    input  logic [REG_AW-1:0] raddr1,
    input  logic [REG_AW-1:0] raddr2,
    output logic [XLEN-1:0]   rdata1,
    output logic [XLEN-1:0]   rdata2
);

    logic [XLEN-1:0] r_mem [NREGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (we && waddr != '0) begin
            r_mem[waddr] <= wdata;
        end
    end

    function automatic logic [XLEN-1:0] rd_port(input logic [REG_AW-1:0] a);
        logic [XLEN-1:0] v;
        v = '0;
        if (a != '0) begin
            v = r_mem[a];
`ifdef ALU_ISSUE_BYPASS_EN
            if (we && waddr == a) begin
                v = wdata;
            end
`endif
        end
        return v;
    endfunction

    assign rdata1 = rd_port(raddr1);
    assign rdata2 = rd_port(raddr2);

endmodule

// File: rtl/alu_issue.sv
// Operand-fetch/issue stage ahead of the ALU with pending-write scoreboard.
// Define ALU_ISSUE_BYPASS_EN to issue dependents in their producer's wb cycle.
module alu_issue
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [31:0]       instr,
    alu_issue_if.master       iss,
    input  logic              wb_en,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [XLEN-1:0]   wb_data
);

    instr_t            w_ins;
    logic [REG_AW-1:0] w_rs2;
    logic [XLEN-1:0]   w_rdata1;
    logic [XLEN-1:0]   w_rdata2;
    logic [NREGS-1:0]  w_clr;
    logic [NREGS-1:0]  w_set;
    logic [NREGS-1:0]  w_pend_eff;
    logic              w_hazard;
    logic              w_xfer;

    logic [NREGS-1:0]  r_pending;
    logic              r_valid;
    logic [XLEN-1:0]   r_op1;
    logic [XLEN-1:0]   r_op2;
    logic [OPW-1:0]    r_op;
    logic [REG_AW-1:0] r_rd;

    assign w_ins = instr_t'(instr);
    assign w_rs2 = w_ins.lo.r.rs2;

    regfile u_rf (
        .clk    (clk),
        .rst    (rst),
        .we     (wb_en),
        .waddr  (wb_addr),
        .wdata  (wb_data),
        .raddr1 (w_ins.rs1),
        .raddr2 (w_rs2),
        .rdata1 (w_rdata1),
        .rdata2 (w_rdata2)
    );

    always_comb begin
        w_clr = '0;
        if (wb_en) begin
            w_clr[wb_addr] = 1'b1;
        end
        w_clr[0] = 1'b0;
    end

    always_comb begin
        w_set = '0;
        if (w_xfer) begin
            w_set[w_ins.rd] = 1'b1;
        end
        w_set[0] = 1'b0;
    end

`ifdef ALU_ISSUE_BYPASS_EN
    assign w_pend_eff = r_pending & ~w_clr;
`else
    assign w_pend_eff = r_pending;
`endif

    assign w_hazard =
        (w_pend_eff[w_ins.rs1] && w_ins.rs1 != '0) ||
        (w_pend_eff[w_rs2] && w_rs2 != '0 && !w_ins.imm_sel) ||
        (w_pend_eff[w_ins.rd] && w_ins.rd != '0);

    assign instr_ready = !rst && !w_hazard && (!r_valid || iss.issue_ready);
    assign w_xfer      = instr_valid && instr_ready;

    // set beats clear when both hit the same register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clr) | w_set;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_op1   <= '0;
            r_op2   <= '0;
            r_op    <= '0;
            r_rd    <= '0;
        end else if (w_xfer) begin
            r_valid <= 1'b1;
            r_op1   <= w_rdata1;
            r_op2   <= w_ins.imm_sel ? sext16(w_ins.lo.imm16) : w_rdata2;
            r_op    <= w_ins.op;
            r_rd    <= w_ins.rd;
        end else if (iss.issue_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign iss.issue_valid = r_valid;
    assign iss.operand1    = r_op1;
    assign iss.operand2    = r_op2;
    assign iss.op          = r_op;
    assign iss.rd_out      = r_rd;

endmodule
